serial_bit_feeder: RTL and testbench

Parallel-in, serial-out feeder that sits directly upstream of the overlapping Moore sequence detectors. It accepts WIDTH-bit words through a valid/ready handshake and drives one bit per clock onto the detector's `data` input. A one-word holding buffer lets consecutive words stream with no idle gap, so overlapping patterns that span word boundaries still reach the detector intact.

---
 rtl/serial_bit_feeder.sv | 107 ++++++++++
 tb/tb_serial_bit_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in, serial-out feeder with a one-word holding
// buffer so consecutive words stream onto the detector with no idle gap.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy
);

  localparam int unsigned    CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] hb, hb_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hold_full, hold_n;
  logic             accept;
  logic [WIDTH-1:0] sr_shifted;
  logic             out_bit;
  logic             data_n, data_valid_n, busy_n, in_ready_n;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    hb_n       = hb;
    cnt_n      = cnt;
    hold_n     = hold_full;
    accept     = in_valid & in_ready;
    sr_shifted = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    case (state)
      S_IDLE: begin
        if (accept) begin
          sr_n    = in_word;
          cnt_n   = '0;
          state_n = S_SHIFT;
        end
      end
      default: begin
        if (cnt != CNT_LAST) begin
          sr_n  = sr_shifted;
          cnt_n = cnt + CNT_W'(1);
          if (accept) begin
            hb_n   = in_word;
            hold_n = 1'b1;
          end
        end else if (hold_full) begin
          // Drain the holding buffer straight into the shifter, no gap
          sr_n   = hb;
          hold_n = 1'b0;
          cnt_n  = '0;
        end else if (accept) begin
          // Word arrives exactly on the last bit: bypass the holding buffer
          sr_n  = in_word;
          cnt_n = '0;
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
    endcase

    out_bit      = (MSB_FIRST != 0) ? sr_n[WIDTH-1] : sr_n[0];
    data_n       = (state_n == S_SHIFT) & out_bit;
    data_valid_n = (state_n == S_SHIFT);
    busy_n       = (state_n == S_SHIFT) | hold_n;
    in_ready_n   = ~hold_n;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      sr         <= '0;
      hb         <= '0;
      cnt        <= '0;
      hold_full  <= 1'b0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      hb         <= hb_n;
      cnt        <= cnt_n;
      hold_full  <= hold_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      busy       <= busy_n;
      in_ready   <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: bit-queue model checked every cycle on an
// MSB-first and an LSB-first instance sharing one input stream.
module tb_serial_bit_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_word = '0;
  logic         in_valid = 1'b0;
  logic         rdy_m, data_m, dv_m, busy_m;
  logic         rdy_l, data_l, dv_l, busy_l;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(rdy_m), .data(data_m), .data_valid(dv_m), .busy(busy_m));

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(rdy_l), .data(data_l), .data_valid(dv_l), .busy(busy_l));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: queue of bits still to appear on data; front is the bit on the wire
  bit q_m[$];
  bit q_l[$];
  int acc_cnt = 0;
  int acc_cyc[$];
  int cyc = 0;
  logic acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      acc = in_valid && (q_m.size() <= W);
      if (q_m.size() > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(in_word[W-1-i]);
          q_l.push_back(in_word[i]);
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Capture / detector bookkeeping used by the directed literal checks
  logic        cap_en = 1'b0;
  logic [31:0] cap_m, cap_l;
  int          cap_n, nrdy, det, hist_n, first_dv, last_dv;
  logic [3:0]  hist;

  task automatic cap_clear();
    cap_m = '0; cap_l = '0; cap_n = 0; nrdy = 0; det = 0;
    hist = '0; hist_n = 0; first_dv = -1; last_dv = -1;
    acc_cyc.delete();
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    cyc++;
    chk("data_msb",  32'(data_m), 32'(q_m.size() > 0 ? q_m[0] : 1'b0));
    chk("data_lsb",  32'(data_l), 32'(q_l.size() > 0 ? q_l[0] : 1'b0));
    chk("dvalid_msb", 32'(dv_m), 32'(q_m.size() > 0));
    chk("dvalid_lsb", 32'(dv_l), 32'(q_l.size() > 0));
    chk("busy_msb",  32'(busy_m), 32'(q_m.size() > 0));
    chk("busy_lsb",  32'(busy_l), 32'(q_l.size() > 0));
    chk("ready_msb", 32'(rdy_m), 32'(q_m.size() <= W));
    chk("ready_lsb", 32'(rdy_l), 32'(q_l.size() <= W));
    if (cap_en) begin
      if (!rdy_m) nrdy++;
      if (dv_m) begin
        cap_m = {cap_m[30:0], data_m};
        cap_l = {cap_l[30:0], data_l};
        cap_n++;
        if (first_dv < 0) first_dv = cyc;
        last_dv = cyc;
        hist = {hist[2:0], data_m};
        hist_n++;
        if (hist_n >= 4 && hist == 4'b1011) det++;
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int start;
    int n;
    start = acc_cnt;
    n = 0;
    in_word = w;
    in_valid = 1'b1;
    while (acc_cnt == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept", 32'(acc_cnt - start), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset held with in_valid asserted
    rst = 1'b0; in_valid = 1'b1; in_word = 8'hB6;
    cycles(2);
    chk("rst_data",  32'(data_m), 32'd0);
    chk("rst_dv",    32'(dv_m),   32'd0);
    chk("rst_busy",  32'(busy_m), 32'd0);
    chk("rst_ready", 32'(rdy_m),  32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    cycles(3);
    chk("rst_no_accept_dv", 32'(dv_m), 32'd0);

    // Single word, MSB first
    cap_clear(); cap_en = 1'b1;
    send(8'hB6);
    cycles(12);
    cap_en = 1'b0;
    chk("single_len",  32'(cap_n), 32'd8);
    chk("single_bits", 32'(cap_m[7:0]), 32'hB6);

    // Streaming three words into a 1011 overlapping detector
    cap_clear(); cap_en = 1'b1;
    send(8'hB6); send(8'hDB); send(8'h6D);
    cycles(30);
    cap_en = 1'b0;
    chk("stream_len",  32'(cap_n), 32'd24);
    chk("stream_bits", cap_m & 32'h00FF_FFFF, 32'h00B6_DB6D);
    chk("stream_nogap", 32'(last_dv - first_dv + 1), 32'd24);
    chk("stream_det",  32'(det), 32'd7);
    chk("stream_acc01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);

    // Holding-buffer backpressure
    cap_clear(); cap_en = 1'b1;
    send(8'hAA); send(8'h55);
    cycles(24);
    cap_en = 1'b0;
    chk("bp_acc_gap",  32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("bp_not_ready", 32'(nrdy), 32'd7);
    chk("bp_len",      32'(cap_n), 32'd16);
    chk("bp_bits",     cap_m & 32'h0000_FFFF, 32'h0000_AA55);

    // LSB first on the second instance
    cap_clear(); cap_en = 1'b1;
    send(8'h0D);
    cycles(12);
    cap_en = 1'b0;
    chk("lsb_bits", 32'(cap_l[7:0]), 32'hB0);
    chk("msb_bits", 32'(cap_m[7:0]), 32'h0D);

    // Reset mid-word with the holding buffer occupied
    send(8'hFF);
    send(8'h0F);
    cycles(2);
    chk("mid_dv_before",   32'(dv_m),   32'd1);
    chk("mid_data_before", 32'(data_m), 32'd1);
    chk("mid_busy_before", 32'(busy_m), 32'd1);
    chk("mid_ready_before", 32'(rdy_m), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_data",  32'(data_m), 32'd0);
    chk("mid_rst_dv",    32'(dv_m),   32'd0);
    chk("mid_rst_busy",  32'(busy_m), 32'd0);
    chk("mid_rst_ready", 32'(rdy_m),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    cap_clear(); cap_en = 1'b1;
    cycles(20);
    cap_en = 1'b0;
    chk("post_rst_silent", 32'(cap_n), 32'd0);

    // Recovery after reset
    cap_clear(); cap_en = 1'b1;
    send(8'hC3);
    cycles(12);
    cap_en = 1'b0;
    chk("recover_bits", 32'(cap_m[7:0]), 32'hC3);
    chk("recover_len",  32'(cap_n), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
